// File: rtl/spectrum_peak_pkg.sv
// Shared constants for the spectrum peak display: digit codes, FSM states,
// frequency width and the Hz saturation helper.
package spectrum_peak_pkg;

    localparam int HZ_WIDTH   = 15;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

    // Digit codes understood by the seven-segment block: 0x00-0x0F are hex
    // glyphs, 0x10 turns the digit off.
    localparam logic [4:0] CODE_HEX_0 = 5'h00;
    localparam logic [4:0] CODE_HEX_F = 5'h0F;
    localparam logic [4:0] CODE_BLANK = 5'h10;

    localparam logic [31:0] HZ_MAX = 32'((1 << HZ_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DABBLE = 2'd2,
        LOAD   = 2'd3
    } state_t;

    function automatic logic [4:0] hex_code(input logic [3:0] nib);
        return CODE_HEX_0 | {1'b0, nib};
    endfunction

    // Clamp a raw bin*Hz product into the displayable range.
    function automatic logic [HZ_WIDTH-1:0] sat_hz(input logic [31:0] prod);
        if (prod > HZ_MAX)
            return HZ_MAX[HZ_WIDTH-1:0];
        return prod[HZ_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per clock. A start pulse
// loads the binary value; done pulses once when the BCD result is ready and
// the result then holds until the next start.
module bin2bcd_seq
    import spectrum_peak_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [HZ_WIDTH-1:0]  bin,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd
);

    localparam int         SR_W  = BCD_WIDTH + HZ_WIDTH;
    localparam logic [3:0] ITERS = 4'(HZ_WIDTH);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_next;
    logic [3:0]      cnt;
    logic            busy;

    // One iteration: correct every BCD digit >= 5, then shift the whole register.
    always_comb begin
        sr_next = sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (sr[HZ_WIDTH + 4*d +: 4] >= 4'd5)
                sr_next[HZ_WIDTH + 4*d +: 4] = sr[HZ_WIDTH + 4*d +: 4] + 4'd3;
        end
        sr_next = sr_next << 1;
    end

    // Load on start, then iterate HZ_WIDTH times and flag completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr   <= {{BCD_WIDTH{1'b0}}, bin};
                cnt  <= ITERS;
                busy <= 1'b1;
            end else if (busy) begin
                sr  <= sr_next;
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr[SR_W-1 -: BCD_WIDTH];

endmodule

// File: rtl/spectrum_peak.sv
// Finds the strongest non-DC bin of each FFT magnitude frame and shows its
// frequency (BCD Hz) and magnitude (hex) on eight seven-segment digits.
// The scanner keeps running while the previous peak is being converted.
module spectrum_peak
    import spectrum_peak_pkg::*;
#(
    parameter int NUM_BINS = 512,
    parameter int MIN_BIN  = 1,
    parameter int BIN_HZ   = 47,
    parameter int THRESH   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       freq_valid,
    input  logic [9:0] freq_addr,
    input  logic [7:0] freq_data,
    output logic [4:0] dig0,
    output logic [4:0] dig1,
    output logic [4:0] dig2,
    output logic [4:0] dig3,
    output logic [4:0] dig4,
    output logic [4:0] dig5,
    output logic [4:0] dig6,
    output logic [4:0] dig7,
    output logic [9:0] peak_bin,
    output logic [7:0] peak_mag,
    output logic       result_valid,
    output logic       frame_err
);

    localparam logic [9:0]  LAST_ADDR = 10'(NUM_BINS - 1);
    localparam logic [9:0]  MIN_ADDR  = 10'(MIN_BIN);
    localparam logic [10:0] NUM_ADDR  = 11'(NUM_BINS);
    localparam logic [31:0] BIN_HZ_W  = 32'(BIN_HZ);
    localparam logic [7:0]  THRESH_W  = 8'(THRESH);

    // Scanner state
    logic       scanning;
    logic [9:0] next_addr;
    logic [9:0] max_bin;
    logic [7:0] max_mag;

    logic       restart, in_order, accept, abort, frame_end, beats;
    logic [9:0] base_bin, upd_bin;
    logic [7:0] base_mag, upd_mag;

    // Conversion state
    state_t               state;
    logic [9:0]           cand_bin;
    logic [7:0]           cand_mag;
    logic [HZ_WIDTH-1:0]  hz;
    logic                 bcd_start;
    logic                 bcd_done;
    logic [BCD_WIDTH-1:0] bcd;
    logic [7:0][4:0]      digs;
    logic [7:0][4:0]      digs_next;
    logic                 lead;

    // Classify the incoming sample and fold it into the running max; addr 0
    // restarts from an empty max so a stale scan never leaks into a new one.
    always_comb begin
        restart   = freq_valid && (freq_addr == 10'd0);
        in_order  = scanning && (freq_addr == next_addr) && ({1'b0, freq_addr} < NUM_ADDR);
        accept    = restart || (freq_valid && in_order);
        abort     = freq_valid && !restart && scanning && !in_order;
        frame_end = accept && (freq_addr == LAST_ADDR);
        base_bin  = restart ? 10'd0 : max_bin;
        base_mag  = restart ? 8'd0  : max_mag;
        beats     = (freq_addr >= MIN_ADDR) && (freq_data > base_mag);
        upd_bin   = beats ? freq_addr : base_bin;
        upd_mag   = beats ? freq_data : base_mag;
    end

    // Running-max register and expected-address tracking for the current scan.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scanning  <= 1'b0;
            next_addr <= '0;
            max_bin   <= '0;
            max_mag   <= '0;
        end else if (accept) begin
            scanning  <= !frame_end;
            next_addr <= freq_addr + 10'd1;
            max_bin   <= upd_bin;
            max_mag   <= upd_mag;
        end else if (abort) begin
            scanning  <= 1'b0;
        end
    end

    assign hz        = sat_hz({22'b0, cand_bin} * BIN_HZ_W);
    assign bcd_start = (state == MULT);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (bcd_start),
        .bin     (hz),
        .done    (bcd_done),
        .bcd     (bcd)
    );

    // Build the digit pattern from the finished BCD value: leading zeros of
    // the Hz field blank, units digit always shown, magnitude in hex on top.
    always_comb begin
        digs_next = {8{CODE_BLANK}};
        lead      = 1'b1;
        if (cand_mag >= THRESH_W) begin
            for (int d = BCD_DIGITS - 1; d >= 0; d--) begin
                lead = lead && (bcd[4*d +: 4] == 4'd0) && (d != 0);
                digs_next[d] = lead ? CODE_BLANK : hex_code(bcd[4*d +: 4]);
            end
            digs_next[7] = hex_code(cand_mag[7:4]);
            digs_next[6] = hex_code(cand_mag[3:0]);
        end
    end

    // Conversion FSM: capture the frame peak, multiply, double-dabble, publish.
    // A frame finishing while a conversion is in flight is reported and dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cand_bin     <= '0;
            cand_mag     <= '0;
            digs         <= {8{CODE_BLANK}};
            peak_bin     <= '0;
            peak_mag     <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            frame_err    <= abort || (frame_end && (state != IDLE));
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        cand_bin <= upd_bin;
                        cand_mag <= upd_mag;
                        state    <= MULT;
                    end
                end
                MULT:   state <= DABBLE;
                DABBLE: if (bcd_done) state <= LOAD;
                LOAD: begin
                    digs         <= digs_next;
                    peak_bin     <= cand_bin;
                    peak_mag     <= cand_mag;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dig0 = digs[0];
    assign dig1 = digs[1];
    assign dig2 = digs[2];
    assign dig3 = digs[3];
    assign dig4 = digs[4];
    assign dig5 = digs[5];
    assign dig6 = digs[6];
    assign dig7 = digs[7];

endmodule

// File: tb/tb_spectrum_peak.sv
// Bench for spectrum_peak: a frame-level reference model predicts every
// output on every cycle, and directed scenarios pin literal results.
module tb_spectrum_peak;

    localparam int NB      = 512;
    localparam int MIN_BIN = 1;
    localparam int BIN_HZ  = 47;
    localparam int THRESH  = 8;
    localparam int LAT     = 18;
    localparam logic [4:0] BL = 5'h10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       freq_valid = 1'b0;
    logic [9:0] freq_addr = '0;
    logic [7:0] freq_data = '0;
    logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
    logic [9:0] peak_bin;
    logic [7:0] peak_mag;
    logic       result_valid, frame_err;

    spectrum_peak #(
        .NUM_BINS (NB),
        .MIN_BIN  (MIN_BIN),
        .BIN_HZ   (BIN_HZ),
        .THRESH   (THRESH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .freq_valid   (freq_valid),
        .freq_addr    (freq_addr),
        .freq_data    (freq_data),
        .dig0         (dig0),
        .dig1         (dig1),
        .dig2         (dig2),
        .dig3         (dig3),
        .dig4         (dig4),
        .dig5         (dig5),
        .dig6         (dig6),
        .dig7         (dig7),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .result_valid (result_valid),
        .frame_err    (frame_err)
    );

    always #20 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit checking = 0;
    int rv_count = 0;
    int err_count = 0;

    // ---------------- reference model state ----------------
    bit          in_frame = 0;
    int          next_addr = 0;
    int          mags[NB];
    bit          pend = 0;
    int          res_at = -1;
    int          pend_bin = 0, pend_mag = 0;
    bit          have_last = 0;
    int          last_end = 0;
    int          err_at = -1;
    int          rv_at = -1;
    int          e_bin = 0, e_mag = 0;
    logic [39:0] e_dig = {8{BL}};

    function automatic logic [39:0] digits_for(input int bin, input int mag);
        logic [7:0][4:0] d;
        int hz, p;
        d = {8{BL}};
        if (mag >= THRESH) begin
            hz = bin * BIN_HZ;
            if (hz > 32767) hz = 32767;
            p = 1;
            for (int k = 0; k < 5; k++) begin
                if (k == 0 || hz >= p) d[k] = 5'((hz / p) % 10);
                p = p * 10;
            end
            d[7] = 5'(mag / 16);
            d[6] = 5'(mag % 16);
        end
        return d;
    endfunction

    task automatic model_sample(input int a, input int v);
        bit ends;
        int best, bb;
        ends = 0;
        if (a == 0) begin
            in_frame  = 1;
            next_addr = 0;
        end
        if (in_frame && a == next_addr) begin
            mags[a] = v;
            next_addr++;
            if (a == NB - 1) begin
                in_frame = 0;
                ends = 1;
            end
        end else if (in_frame) begin
            in_frame = 0;
            err_at = cyc;
        end
        if (ends) begin
            if (have_last && (cyc - last_end) <= LAT) begin
                err_at = cyc;
            end else begin
                best = 0;
                bb = 0;
                for (int b = MIN_BIN; b < NB; b++)
                    if (mags[b] > best) begin
                        best = mags[b];
                        bb = b;
                    end
                pend = 1;
                pend_bin = bb;
                pend_mag = best;
                res_at = cyc + LAT;
                last_end = cyc;
                have_last = 1;
            end
        end
    endtask

    // Model: observe the bench's own stimulus at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                in_frame = 0; pend = 0; have_last = 0;
                err_at = -1; rv_at = -1;
                e_bin = 0; e_mag = 0; e_dig = {8{BL}};
            end else begin
                if (pend && cyc == res_at) begin
                    pend = 0;
                    rv_at = cyc;
                    e_bin = pend_bin;
                    e_mag = pend_mag;
                    e_dig = digits_for(pend_bin, pend_mag);
                end
                if (freq_valid) model_sample(int'(freq_addr), int'(freq_data));
            end
        end
    end

    // Compare: every cycle, all outputs against the model.
    initial begin
        logic [59:0] got, want;
        forever begin
            @(negedge clk);
            if (checking) begin
                got  = {result_valid, frame_err, peak_bin, peak_mag,
                        dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
                want = {rv_at == cyc, err_at == cyc, 10'(e_bin), 8'(e_mag), e_dig};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL cycle %0d outputs: got rv=%b err=%b bin=%0d mag=%0d dig=%h, want rv=%b err=%b bin=%0d mag=%0d dig=%h",
                             cyc, got[59], got[58], got[57:48], got[47:40], got[39:0],
                             want[59], want[58], want[57:48], want[47:40], want[39:0]);
                end
                if (result_valid === 1'b1) rv_count++;
                if (frame_err === 1'b1) err_count++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int fr[NB];
    logic [39:0] snap [$];

    task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic drive(input bit v, input int a, input int d);
        @(negedge clk);
        freq_valid = v;
        freq_addr  = 10'(a);
        freq_data  = 8'(d);
        if (result_valid === 1'b1) snap.push_back({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0});
    endtask

    task automatic send_frame();
        for (int i = 0; i < NB; i++) drive(1, i, fr[i]);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NB; i++) fr[i] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic wait_rv(input string name, input int limit, output int n);
        n = 0;
        do begin
            drive(0, 0, 0);
            n++;
        end while (result_valid !== 1'b1 && n < limit);
        if (result_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: result_valid absent after %0d cycles, want a pulse", name, limit);
        end
    endtask

    function automatic logic [63:0] digs_now();
        return 64'({dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0});
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n, rv0, er0;
        logic [39:0] d_t2;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1;
        check_lit("reset digits", digs_now(), 64'({8{BL}}));
        check_lit("reset peak_bin", 64'(peak_bin), 64'd0);
        check_lit("reset peak_mag", 64'(peak_mag), 64'd0);
        check_lit("reset result_valid", 64'(result_valid), 64'd0);
        reset_n = 1'b1;
        idle(3);

        // DC excluded, weak peak -> blank display but outputs still update
        for (int i = 0; i < NB; i++) fr[i] = i % 6;
        fr[0] = 255;
        send_frame();
        wait_rv("dc", 40, n);
        check_lit("dc peak_bin", 64'(peak_bin), 64'd5);
        check_lit("dc peak_mag", 64'(peak_mag), 64'd5);
        check_lit("dc digits", digs_now(), 64'({8{BL}}));
        idle(3);

        // Main case: bin 100 = 200 -> 4700 Hz, C8
        fill(2);
        fr[100] = 200;
        send_frame();
        wait_rv("main", 40, n);
        check_lit("main latency", 64'(n), 64'(LAT + 1));
        check_lit("main peak_bin", 64'(peak_bin), 64'd100);
        check_lit("main peak_mag", 64'(peak_mag), 64'd200);
        check_lit("main digits", digs_now(),
                  64'({5'h0C, 5'h08, BL, BL, 5'h04, 5'h07, 5'h00, 5'h00}));
        drive(0, 0, 0);
        check_lit("main single pulse", 64'(result_valid), 64'd0);
        idle(3);

        // Tie: lowest bin wins -> bin 30, 1410 Hz, 5A
        fill(1);
        fr[30] = 90;
        fr[60] = 90;
        send_frame();
        wait_rv("tie", 40, n);
        d_t2 = {5'h05, 5'h0A, BL, BL, 5'h01, 5'h04, 5'h01, 5'h00};
        check_lit("tie peak_bin", 64'(peak_bin), 64'd30);
        check_lit("tie digits", digs_now(), 64'(d_t2));
        idle(3);

        // Address skip 40 -> 42, then out-of-range address
        rv0 = rv_count;
        er0 = err_count;
        fill(4);
        fr[80] = 250;
        for (int i = 0; i <= 40; i++) drive(1, i, fr[i]);
        for (int i = 42; i < 100; i++) drive(1, i, fr[i]);
        idle(5);
        check_lit("skip frame_err count", 64'(err_count - er0), 64'd1);
        check_lit("skip no result", 64'(rv_count - rv0), 64'd0);
        check_lit("skip digits held", digs_now(), 64'(d_t2));
        check_lit("skip peak_bin held", 64'(peak_bin), 64'd30);
        for (int i = 0; i < 4; i++) drive(1, i, 1);
        drive(1, 600, 1);
        idle(3);
        check_lit("range frame_err count", 64'(err_count - er0), 64'd2);

        // Restart mid-scan without error, then a clean frame: bin 255 = 60
        er0 = err_count;
        for (int i = 0; i < 10; i++) drive(1, i, 77);
        fill(6);
        fr[255] = 60;
        send_frame();
        wait_rv("restart", 40, n);
        check_lit("restart no frame_err", 64'(err_count - er0), 64'd0);
        check_lit("restart digits", digs_now(),
                  64'({5'h03, 5'h0C, BL, 5'h01, 5'h01, 5'h09, 5'h08, 5'h05}));
        idle(3);

        // Reset five cycles into the BCD conversion
        fill(3);
        fr[200] = 50;
        send_frame();
        idle(6);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check_lit("midreset digits", digs_now(), 64'({8{BL}}));
        check_lit("midreset peak_bin", 64'(peak_bin), 64'd0);
        rv0 = rv_count;
        idle(30);
        check_lit("midreset no result", 64'(rv_count - rv0), 64'd0);
        fill(3);
        fr[300] = 100;
        send_frame();
        wait_rv("after reset", 40, n);
        check_lit("after reset digits", digs_now(),
                  64'({5'h06, 5'h04, BL, 5'h01, 5'h04, 5'h01, 5'h00, 5'h00}));
        idle(3);

        // Back-to-back frames, freq_valid held high throughout
        rv0 = rv_count;
        snap.delete();
        fill(3);
        fr[10] = 100;
        send_frame();
        fr[10] = 3;
        fr[20] = 100;
        send_frame();
        wait_rv("b2b", 40, n);
        check_lit("b2b result count", 64'(rv_count - rv0), 64'd2);
        check_lit("b2b snapshots", 64'(snap.size()), 64'd2);
        if (snap.size() == 2) begin
            check_lit("b2b first digits", 64'(snap[0]),
                      64'({5'h06, 5'h04, BL, BL, BL, 5'h04, 5'h07, 5'h00}));
            check_lit("b2b second digits", 64'(snap[1]),
                      64'({5'h06, 5'h04, BL, BL, BL, 5'h09, 5'h04, 5'h00}));
        end
        check_lit("b2b peak_bin", 64'(peak_bin), 64'd20);
        idle(5);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spectrum_peak.md
SPECTRUM_PEAK -- requirements
Module: spectrum_peak

Interface
REQ-001 SHALL have parameter NUM_BINS, default 512: bins per frame scanned (addresses 0..NUM_BINS-1).
REQ-002 SHALL have parameter MIN_BIN, default 1: lowest bin eligible for peak, which excludes DC.
REQ-003 SHALL have parameter BIN_HZ, default 47: Hz per bin (48 kHz / 1024).
REQ-004 SHALL have parameter THRESH, default 8: minimum peak magnitude displayed.
REQ-005 SHALL have port clk, input, 1: frequency-domain clock (25 MHz video clock); the only clock.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port freq_valid, input, 1: FFT magnitude sample strobe.
REQ-008 SHALL have port freq_addr, input, 10: bin index of the sample.
REQ-009 SHALL have port freq_data, input, 8: bin magnitude, unsigned.
REQ-010 SHALL have ports dig0..dig7, output, 5 each: seven-segment digit codes for the sevensegment block.
REQ-011 SHALL have port peak_bin, output, 10: bin of the last accepted peak.
REQ-012 SHALL have port peak_mag, output, 8: magnitude of the last accepted peak.
REQ-013 SHALL have port result_valid, output, 1: one-cycle pulse when outputs update.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse when a frame is discarded.

Function
REQ-015 SHALL sample inputs only when freq_valid=1; cycles with freq_valid=0 are ignored.
REQ-016 SHALL start a new scan on any valid sample with freq_addr=0, abandoning any scan in progress without error.
REQ-017 SHALL require consecutive valid addresses to increment by exactly 1; a mismatch or freq_addr>=NUM_BINS SHALL abort the scan, pulse frame_err the next cycle, and ignore samples until the next addr 0.
REQ-018 SHALL update the running max only on freq_addr>=MIN_BIN with freq_data strictly greater than the current max; ties keep the lowest bin.
REQ-019 SHALL treat the running max as 0 / bin 0 at scan start.
REQ-020 SHALL end a frame on the valid sample with freq_addr=NUM_BINS-1; the final sample SHALL participate in the compare.
REQ-021 Conversion FSM SHALL have states IDLE, MULT, DABBLE, LOAD.
REQ-022 IDLE->MULT SHALL occur on frame end.
REQ-023 MULT SHALL compute hz = peak_bin*BIN_HZ as a 15-bit value, saturating at 32767.
REQ-024 DABBLE SHALL perform 15 shift/add-3 iterations to produce 5 BCD digits.
REQ-025 LOAD SHALL update all outputs and return to IDLE.
REQ-026 result_valid SHALL pulse exactly 18 cycles after the clock edge accepting the final sample.
REQ-027 Scanning SHALL run concurrently with conversion.
REQ-028 A frame ending while the FSM is not IDLE SHALL be dropped and SHALL pulse frame_err.
REQ-029 When peak_mag>=THRESH, dig4..dig0 SHALL show hz in BCD, most-significant digit in dig4, with leading zeros blanked and dig0 never blanked.
REQ-030 When peak_mag>=THRESH, dig5 SHALL be blank and dig7..dig6 SHALL show peak_mag in hex.
REQ-031 When peak_mag<THRESH, all digits SHALL be CODE_BLANK; peak_bin, peak_mag and result_valid SHALL still update.
REQ-032 Outputs SHALL hold their values between result_valid pulses.

Reset
REQ-033 While reset_n=0 at a clk edge: FSM to IDLE, scan aborted and awaiting addr 0, dig0..dig7 = CODE_BLANK, peak_bin=0, peak_mag=0, result_valid=0, frame_err=0.
REQ-034 Reset mid-scan or mid-conversion SHALL discard all partial results, with no result_valid or frame_err pulse.

Structure
REQ-035 A shared package SHALL hold CODE_BLANK (5'h10), hex digit codes 0-F (5'h00-5'h0F), the FSM state encoding, and HZ_WIDTH=15.
REQ-036 The block SHALL have one sub-module, bin2bcd_seq: sequential 15-bit double-dabble with start/done handshake.

Verification
REQ-037 Bench SHALL run a full frame, all bins 2 except bin 100=200 -> 18 cycles after the last bin: peak_bin=100, peak_mag=200, dig4..0 = blank,4,7,0,0, dig7..6 = C,8, dig5 blank.
REQ-038 Bench SHALL run a tie case, bins 30 and 60 both =90 -> peak_bin=30, hz 1410 shown.
REQ-039 Bench SHALL run bin 0=255, all others <=5 -> peak excludes DC, peak_mag<8 -> all digits blank, result_valid pulses.
REQ-040 Bench SHALL run an address skip 40->42 -> frame_err pulse, no result_valid, prior digits unchanged; the next clean frame updates normally.
REQ-041 Bench SHALL pull reset_n low 5 cycles into DABBLE -> digits blank, no result_valid; the following frame yields a correct result.
REQ-042 Bench SHALL run back-to-back frames with freq_valid asserted continuously and peaks at bins 10 then 20 -> two result_valid pulses, hz 470 then 940.
